// File: rtl/signal_change_logger.sv
// -----------------------------------------------------------------------------
// signal_change_logger
//   Captures every value change on a watched bus together with a free-running
//   cycle timestamp. Each (timestamp, value) record goes into a small circular
//   FIFO, and a reader drains the FIFO over a valid/ready handshake.
//
// Ports
//   clock          single clock, rising edge
//   reset          synchronous active-high reset
//   sig_in         watched bus (already synchronous to clock)
//   clear_overflow clears the sticky overflow flag (a drop in the same edge wins)
//   rd_valid       head record available
//   rd_ready       reader accepts the head record
//   rd_time        timestamp of the head record
//   rd_value       sig_in value of the head record
//   overflow       sticky: at least one record was dropped
//   level          current FIFO occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module signal_change_logger #(
  parameter int WIDTH    = 2,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sig_in,
  input  logic                     clear_overflow,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_WIDTH-1:0]      rd_time,
  output logic [WIDTH-1:0]         rd_value,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [TS_WIDTH-1:0] TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW:0]         PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [TS_WIDTH-1:0] time_mem_r  [DEPTH];
  logic [WIDTH-1:0]    value_mem_r [DEPTH];
  logic [AW:0]         wr_ptr_r;
  logic [AW:0]         rd_ptr_r;
  logic [TS_WIDTH-1:0] ts_r;
  logic [WIDTH-1:0]    prev_r;
  logic                first_r;
  logic                overflow_r;

  logic                push_req_s;
  logic                pop_s;
  logic                full_s;
  logic                push_ok_s;
  logic                drop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level    = wr_ptr_r - rd_ptr_r;
  assign rd_valid = (level != {(AW+1){1'b0}});
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // Head record is read straight from storage so a pop exposes the next
  // entry in the following cycle without a bubble.
  assign rd_time  = time_mem_r[rd_ptr_r[AW-1:0]];
  assign rd_value = value_mem_r[rd_ptr_r[AW-1:0]];
  assign overflow = overflow_r;

  // Push/pop decisions for the current edge.
  always_comb begin
    push_req_s = 1'b0;
    pop_s      = 1'b0;
    push_ok_s  = 1'b0;
    drop_s     = 1'b0;
    if (first_r || (sig_in != prev_r)) begin
      push_req_s = 1'b1;
    end else begin
      push_req_s = 1'b0;
    end
    pop_s = rd_valid && rd_ready;
    // A pop in the same edge frees the slot a full FIFO needs.
    if (push_req_s && (!full_s || pop_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
    drop_s = push_req_s && full_s && !pop_s;
  end

  // Timestamp, change detector, FIFO storage/pointers and overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_r       <= {TS_WIDTH{1'b0}};
      prev_r     <= {WIDTH{1'b0}};
      first_r    <= 1'b1;
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        time_mem_r[i]  <= {TS_WIDTH{1'b0}};
        value_mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      ts_r    <= ts_r + TS_ONE;
      prev_r  <= sig_in;
      first_r <= 1'b0;
      if (push_ok_s) begin
        time_mem_r[wr_ptr_r[AW-1:0]]  <= ts_r;
        value_mem_r[wr_ptr_r[AW-1:0]] <= sig_in;
        wr_ptr_r                      <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      // A drop in the same edge overrides a clear request.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_signal_change_logger.sv
// -----------------------------------------------------------------------------
// tb_signal_change_logger
//   Drives directed and random stimulus into signal_change_logger and compares
//   every cycle against a queue-based reference model. A second instance with
//   a 4-bit timestamp checks timestamp wrap-around.
// -----------------------------------------------------------------------------
module tb_signal_change_logger;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  sig_in;
  logic        clear_overflow;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_time;
  logic [1:0]  rd_value;
  logic        overflow;
  logic [3:0]  level;

  logic        w_reset;
  logic [1:0]  w_sig;
  logic        w_clear;
  logic        w_valid;
  logic        w_ready;
  logic [3:0]  w_time;
  logic [1:0]  w_value;
  logic        w_overflow;
  logic [3:0]  w_level;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state.
  logic [15:0] m_tq[$];
  logic [1:0]  m_vq[$];
  logic [15:0] m_ts;
  logic        m_first;
  logic [1:0]  m_prev;
  logic        m_ovf;

  always #5 clock = ~clock;

  signal_change_logger #(.WIDTH(2), .TS_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sig_in(sig_in),
    .clear_overflow(clear_overflow), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_time(rd_time), .rd_value(rd_value), .overflow(overflow), .level(level)
  );

  signal_change_logger #(.WIDTH(2), .TS_WIDTH(4), .DEPTH(DEPTH)) dut_wrap (
    .clock(clock), .reset(w_reset), .sig_in(w_sig),
    .clear_overflow(w_clear), .rd_valid(w_valid), .rd_ready(w_ready),
    .rd_time(w_time), .rd_value(w_value), .overflow(w_overflow), .level(w_level)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Applies one edge to the model from the rules of the logger.
  task automatic model_edge(input logic r, input logic [1:0] s, input logic rr, input logic clr);
    logic req, pop, drop;
    if (r) begin
      m_tq.delete();
      m_vq.delete();
      m_ts    = 16'd0;
      m_first = 1'b1;
      m_prev  = 2'd0;
      m_ovf   = 1'b0;
    end else begin
      req  = m_first || (s != m_prev);
      pop  = (m_tq.size() != 0) && rr;
      drop = req && !pop && (m_tq.size() == DEPTH);
      if (pop) begin
        void'(m_tq.pop_front());
        void'(m_vq.pop_front());
      end
      if (req && !drop) begin
        m_tq.push_back(m_ts);
        m_vq.push_back(s);
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_ts    = m_ts + 16'd1;
      m_prev  = s;
      m_first = 1'b0;
    end
  endtask

  // One clock cycle on the main instance with full output comparison.
  task automatic step(input logic r, input logic [1:0] s, input logic rr, input logic clr);
    reset          = r;
    sig_in         = s;
    rd_ready       = rr;
    clear_overflow = clr;
    @(posedge clock);
    model_edge(r, s, rr, clr);
    #1;
    check_val("rd_valid", {31'd0, rd_valid}, {31'd0, (m_tq.size() != 0)});
    check_val("level", {28'd0, level}, m_tq.size());
    check_val("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (m_tq.size() != 0) begin
      check_val("rd_time", {16'd0, rd_time}, {16'd0, m_tq[0]});
      check_val("rd_value", {30'd0, rd_value}, {30'd0, m_vq[0]});
    end
    if (r) begin
      check_val("rst_time", {16'd0, rd_time}, 32'd0);
      check_val("rst_value", {30'd0, rd_value}, 32'd0);
    end
  endtask

  initial begin
    logic [1:0] s;
    reset = 1'b1; sig_in = 2'b01; rd_ready = 1'b1; clear_overflow = 1'b0;
    w_reset = 1'b1; w_sig = 2'b00; w_clear = 1'b0; w_ready = 1'b0;
    m_ts = 16'd0; m_first = 1'b1; m_prev = 2'd0; m_ovf = 1'b0;

    // Initial record: one {0, 01} record then nothing.
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 2'b01, 1'b1, 1'b0);

    // Clock-like toggling on bit 1, bit 0 drops at cycle 50.
    step(1'b1, 2'b00, 1'b1, 1'b0);
    for (int c = 0; c < 80; c++)
      step(1'b0, {((c / 5) % 2) == 1, c < 50}, 1'b1, 1'b0);

    // Overflow: fill with no reader, 12 changing samples.
    step(1'b1, 2'b00, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) step(1'b0, 2'(c + 1), 1'b0, 1'b0);
    check_val("ovf_level", {28'd0, level}, 32'd8);
    check_val("ovf_flag", {31'd0, overflow}, 32'd1);

    // Full with simultaneous pop and push, clear overflow in the same edge.
    step(1'b0, 2'b10, 1'b1, 1'b1);
    check_val("fullpp_level", {28'd0, level}, 32'd8);
    check_val("fullpp_ovf", {31'd0, overflow}, 32'd0);

    // Drain to 3 records, overflow again first, then reset with reader ready.
    step(1'b0, 2'b11, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, 2'b11, 1'b1, 1'b0);
    check_val("pre_rst_level", {28'd0, level}, 32'd3);
    check_val("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    check_val("rst_level", {28'd0, level}, 32'd0);
    check_val("rst_valid", {31'd0, rd_valid}, 32'd0);
    step(1'b0, 2'b10, 1'b0, 1'b0);
    check_val("post_rst_time", {16'd0, rd_time}, 32'd0);
    check_val("post_rst_value", {30'd0, rd_value}, 32'd2);

    // Random traffic with bursty reader, occasional clear and reset.
    s = 2'b10;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) s = 2'($urandom);
      step(($urandom_range(0, 299) == 0),
           s,
           ((c / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0));
    end

    // Timestamp wrap on the 4-bit instance: change at cycle 17 logs time 1.
    reset = 1'b1;
    @(posedge clock); #1;
    w_reset = 1'b0; w_sig = 2'b00;
    for (int k = 0; k < 20; k++) begin
      if (k == 17) w_sig = 2'b11;
      @(posedge clock); #1;
    end
    check_val("wrap_level", {28'd0, w_level}, 32'd2);
    check_val("wrap_t0", {28'd0, w_time}, 32'd0);
    check_val("wrap_v0", {30'd0, w_value}, 32'd0);
    w_ready = 1'b1;
    @(posedge clock); #1;
    w_ready = 1'b0;
    check_val("wrap_t1", {28'd0, w_time}, 32'd1);
    check_val("wrap_v1", {30'd0, w_value}, 32'd3);
    check_val("wrap_level2", {28'd0, w_level}, 32'd1);
    check_val("wrap_ovf", {31'd0, w_overflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/signal_change_logger.md
# signal_change_logger

- Synthesizable change logger that captures every value change on a watched bus, together with a cycle timestamp.
- Buffers the (timestamp, value) records in an internal FIFO.
- A downstream reader drains the records over a valid/ready handshake.
- Hardware counterpart of a simulation value monitor: on-chip trace capture of control signals such as clock-enables and resets, read out by a debug or host interface.

## Interface

Parameters:
- WIDTH, 2, width of the watched bus
- TS_WIDTH, 16, width of the free-running timestamp counter
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2

Ports:
- clock  input  1  single clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- sig_in  input  WIDTH  watched bus, already synchronous to clock
- clear_overflow  input  1  clears the sticky overflow flag
- rd_valid  output  1  head record available
- rd_ready  input  1  reader accepts the head record
- rd_time  output  TS_WIDTH  timestamp of the head record
- rd_value  output  WIDTH  sig_in value of the head record
- overflow  output  1  sticky: at least one record was dropped
- level  output  log2(DEPTH)+1  current FIFO occupancy

## Operation

Timestamp counter (ts):
- reset: ts <= 0.
- Otherwise ts <= ts + 1 every edge, modulo 2^TS_WIDTH. Wraps silently.

Change detection:
- Register prev holds sig_in as sampled at the previous edge.
- Flag first is set by reset and cleared by the first non-reset edge.
- At each non-reset edge, a push is requested if first==1 or sig_in != prev.
- The pushed record is {ts (pre-increment value), sig_in}. The first edge after reset release therefore always logs {0, sig_in}.
- prev <= sig_in on every non-reset edge, whether or not the push is accepted.

FIFO:
- Circular buffer, DEPTH entries, read/write pointers with one extra wrap bit.
- Pop occurs when rd_valid && rd_ready at an edge.
- Push is accepted if level < DEPTH, or if a pop occurs in the same edge (full + simultaneous pop + push: both happen, level stays DEPTH).
- Push while full with no pop: record is dropped, FIFO unchanged, overflow <= 1.
- Empty + push + rd_ready: no pop that edge (rd_valid was 0); the record appears next cycle.

Overflow flag:
- overflow <= 0 on reset.
- A clear_overflow edge sets it to 0 unless a drop occurs in the same edge; the drop wins and overflow stays 1.

Outputs:
- rd_valid = (level != 0).
- rd_time and rd_value show the head entry directly from the pointer; they are stable while rd_valid && !rd_ready.
- rd_time and rd_value are don't-care when rd_valid==0; they must not be X after reset (storage reset to 0).

Reset values:
- rd_valid=0, level=0, overflow=0, rd_time=0, rd_value=0, ts=0, first=1, prev=0, both pointers 0.
- Reset mid-operation discards all buffered records and the overflow state in that edge.
- Any push or pop requested in the reset edge is ignored.

## Timing

- Change latency: sig_in changes before edge N, record written at edge N, rd_valid=1 after edge N if the FIFO was empty.
- Record time equals the number of edges since reset release, counting the release edge as 0.
- Pop-to-next-head: zero bubble. After a pop at edge N, the next record (if any) is presented in the same cycle following edge N.
- Sustained throughput: one push and one pop per cycle.
- Overflow sets on the edge of the first dropped push.

## Test plan

1. Initial record:
   - Stimulus: reset 5 cycles with sig_in=2'b01, release, hold sig_in, rd_ready=1.
   - Response: exactly one record {0, 01}, then rd_valid=0 indefinitely.
2. Clock-like toggling:
   - Stimulus: sig_in[1] toggles every 5 cycles, sig_in[0]=1 until cycle 50 then 0, rd_ready=1.
   - Response: records at times 0, 5, 10, …, 45, then {50, value with bit0=0}, then every 5 cycles.
   - No record when the bus is unchanged.
3. Overflow:
   - Stimulus: DEPTH=8, rd_ready=0, sig_in increments every cycle for 12 cycles.
   - Response: level=8, records times 0–7, overflow=1 from edge 8.
   - After draining, clear_overflow gives overflow=0.
4. Full with simultaneous pop and push:
   - Stimulus: FIFO full, rd_ready=1 for 1 cycle while sig_in changes.
   - Response: level stays 8, the new record is retained, overflow stays 0.
5. Timestamp wrap:
   - Stimulus: TS_WIDTH=4, single change at cycle 17.
   - Response: record time=1.
6. Reset mid-operation:
   - Stimulus: 3 records buffered, overflow=1, assert reset 1 cycle with rd_ready=1.
   - Response: after the reset edge, rd_valid=0, level=0, overflow=0.
   - First post-release record is {0, sig_in}.
